// File: rtl/db_ram_burst_rd_if.sv
// Shared bus bundle for the deblocking RAM burst reader: the single-port RAM
// pins plus the downstream valid/ready read stream.
interface db_ram_burst_rd_if #(
    parameter int Word_Width = 128,
    parameter int Addr_Width = 8
);
    logic                  cen_o;
    logic                  oen_o;
    logic                  wen_o;
    logic [Addr_Width-1:0] addr_o;
    logic [Word_Width-1:0] data_o;
    logic [Word_Width-1:0] ram_data_i;
    logic                  rd_valid_o;
    logic [Word_Width-1:0] rd_data_o;
    logic                  rd_ready_i;

    modport master (
        output cen_o, oen_o, wen_o, addr_o, data_o, rd_valid_o, rd_data_o,
        input  ram_data_i, rd_ready_i
    );

    modport slave (
        input  cen_o, oen_o, wen_o, addr_o, data_o, rd_valid_o, rd_data_o,
        output ram_data_i, rd_ready_i
    );
endinterface

// File: rtl/db_ram_burst_rd.sv
// Burst read controller for the deblocking single-port RAM: streams a burst of
// words through a 2-entry FIFO while giving filter write-backs priority on the port.
module db_ram_burst_rd #(
    parameter int Word_Width = 128,
    parameter int Addr_Width = 8,
    parameter int Len_Width  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [Addr_Width-1:0] base_addr_i,
    input  logic [Len_Width-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  wr_en_i,
    input  logic [Addr_Width-1:0] wr_addr_i,
    input  logic [Word_Width-1:0] wr_data_i,
    db_ram_burst_rd_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [Addr_Width-1:0] rd_addr_r;
    logic [Len_Width-1:0]  remain_r;
    logic                  inflight_r;
    logic [Word_Width-1:0] fifo_mem_r [2];
    logic                  wptr_r;
    logic                  rptr_r;
    logic [1:0]            fifo_cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  oen_r;

    logic                  pop_s;
    logic                  push_s;
    logic                  credit_s;
    logic                  issue_s;
    logic                  launch_s;
    logic                  busy_s;
    logic                  done_s;

    assign pop_s  = bus.rd_valid_o & bus.rd_ready_i;
    assign push_s = inflight_r;
    // The in-flight word already owns a FIFO slot, so it is counted as occupancy.
    assign credit_s = (({1'b0, fifo_cnt_r} + {2'b00, inflight_r}) - {2'b00, pop_s}) < 3'd2;

    // Next-state logic and per-cycle FSM decisions.
    always_comb begin
        state_s  = state_r;
        issue_s  = 1'b0;
        launch_s = 1'b0;
        busy_s   = busy_r;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != {Len_Width{1'b0}}) begin
                        state_s  = ST_READ;
                        launch_s = 1'b1;
                        busy_s   = 1'b1;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if ((remain_r != {Len_Width{1'b0}}) && !wr_en_i && credit_s) begin
                    issue_s = 1'b1;
                    if (remain_r == Len_Width'(1)) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!inflight_r && ((fifo_cnt_r == 2'd0) || ((fifo_cnt_r == 2'd1) && pop_s))) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // FSM state and status output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Read pointer/count, in-flight tracking and the 2-entry output FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_r  <= {Addr_Width{1'b0}};
            remain_r   <= {Len_Width{1'b0}};
            inflight_r <= 1'b0;
            wptr_r     <= 1'b0;
            rptr_r     <= 1'b0;
            fifo_cnt_r <= 2'd0;
            oen_r      <= 1'b1;
        end else begin
            oen_r      <= 1'b0;
            inflight_r <= issue_s;
            if (launch_s) begin
                rd_addr_r <= base_addr_i;
                remain_r  <= len_i;
            end else if (issue_s) begin
                rd_addr_r <= rd_addr_r + Addr_Width'(1);
                remain_r  <= remain_r - Len_Width'(1);
            end
            if (push_s) begin
                fifo_mem_r[wptr_r] <= bus.ram_data_i;
                wptr_r             <= ~wptr_r;
            end
            if (pop_s) begin
                rptr_r <= ~rptr_r;
            end
            fifo_cnt_r <= (fifo_cnt_r + {1'b0, push_s}) - {1'b0, pop_s};
        end
    end

    // RAM port arbitration: a write-back always wins the slot over a burst read.
    always_comb begin
        bus.cen_o  = 1'b1;
        bus.wen_o  = 1'b1;
        bus.addr_o = rd_addr_r;
        if (wr_en_i) begin
            bus.cen_o  = 1'b0;
            bus.wen_o  = 1'b0;
            bus.addr_o = wr_addr_i;
        end else if (issue_s) begin
            bus.cen_o  = 1'b0;
            bus.wen_o  = 1'b1;
            bus.addr_o = rd_addr_r;
        end else begin
            bus.cen_o  = 1'b1;
            bus.wen_o  = 1'b1;
            bus.addr_o = rd_addr_r;
        end
    end

    assign bus.data_o     = wr_data_i;
    assign bus.oen_o      = oen_r;
    assign bus.rd_valid_o = (fifo_cnt_r != 2'd0);
    assign bus.rd_data_o  = fifo_mem_r[rptr_r];
    assign busy_o         = busy_r;
    assign done_o         = done_r;

endmodule
